qblock_sprite_ctrl: RTL and testbench

- Upstream driver for the question-block sprite ROMs (20x20, 400-entry, 9-bit address, 24-bit colour out).
- Maps the current raster position (DrawX/DrawY) to a ROM read address.
- Runs the blink/bump/used animation state machine, which selects one of four sprite frames.
- Applies transparency to the colour returned by the ROM mux and emits a registered pixel_on/pixel_color pair for the compositor.

---
 rtl/qblock_pkg.sv | 34 +++
 rtl/qblock_anim_fsm.sv | 98 +++++++++
 rtl/qblock_sprite_ctrl.sv | 95 +++++++++
 tb/tb_qblock_sprite_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qblock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qblock_pkg
// Purpose  : Shared types and constants for the question-block sprite path
// Revision : 1.0  initial release
// ============================================================================
package qblock_pkg;

    // Animation modes of the block
    typedef enum logic [1:0] {
        BLINK = 2'd0,
        BUMP  = 2'd1,
        USED  = 2'd2
    } anim_state_t;

    // Frame index of the spent ("used") block artwork
    localparam logic [1:0] FRAME_USED = 2'd3;

    // Vertical lift (pixels) for each frame of the bump animation
    localparam int BUMP_LEN = 8;
    localparam logic [BUMP_LEN-1:0][3:0] BUMP_OFS = {
        4'd2, 4'd4, 4'd6, 4'd8, 4'd8, 4'd6, 4'd4, 4'd2
    };

    // Magenta key colour in the sprite ROMs
    localparam logic [23:0] TRANSPARENT_RGB = 24'h800080;

    // Blink phases 0,1,2,3 show frames 0,1,2,1 (ping-pong shimmer)
    function automatic logic [1:0] blink_frame(input logic [1:0] phase);
        return (phase == 2'd3) ? 2'd1 : phase;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qblock_anim_fsm.sv
`default_nettype none
// ============================================================================
// Module   : qblock_anim_fsm
// Purpose  : Blink / bump / used animation sequencer; yields frame and lift
// Revision : 1.0  initial release
// ============================================================================
module qblock_anim_fsm
    import qblock_pkg::*;
#(
    parameter int HOLD_FRAMES = 8,
    parameter int BUMP_FRAMES = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick_i,
    input  logic       hit_i,
    output logic [1:0] frame_sel_o,
    output logic [3:0] y_off_o
);

    localparam int              HCW       = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_FRAMES - 1);
    localparam logic [2:0]      BUMP_LAST = 3'(BUMP_FRAMES - 1);

    anim_state_t    state_q, state_d;
    logic [1:0]     phase_q, phase_d;
    logic [HCW-1:0] hold_q,  hold_d;
    logic [2:0]     bump_q,  bump_d;

    // State register with synchronous reset back to the first blink frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= BLINK;
            phase_q <= 2'd0;
            hold_q  <= '0;
            bump_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            bump_q  <= bump_d;
        end
    end

    // Next-state logic: a hit pre-empts a coincident tick in BLINK
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        bump_d  = bump_q;
        case (state_q)
            BLINK: begin
                if (hit_i) begin
                    state_d = BUMP;
                    bump_d  = 3'd0;
                end else if (frame_tick_i) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        phase_d = phase_q + 2'd1;
                    end else begin
                        hold_d  = hold_q + HCW'(1);
                    end
                end
            end
            BUMP: begin
                if (frame_tick_i) begin
                    if (bump_q == BUMP_LAST) begin
                        state_d = USED;
                    end else begin
                        bump_d  = bump_q + 3'd1;
                    end
                end
            end
            default: begin
                // USED is terminal until reset
            end
        endcase
    end

    // Output decode: artwork frame and upward lift for the current state
    always_comb begin
        frame_sel_o = blink_frame(phase_q);
        y_off_o     = 4'd0;
        case (state_q)
            BUMP: begin
                frame_sel_o = FRAME_USED;
                y_off_o     = BUMP_OFS[bump_q];
            end
            USED: begin
                frame_sel_o = FRAME_USED;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/qblock_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qblock_sprite_ctrl
// Purpose  : Raster-to-ROM addressing, animation and transparency for the
//            question-block sprite; two-stage free-running pipeline
// Revision : 1.0  initial release
// ============================================================================
module qblock_sprite_ctrl
    import qblock_pkg::*;
#(
    parameter int          SPRITE_W    = 20,
    parameter int          SPRITE_H    = 20,
    parameter int          HOLD_FRAMES = 8,
    parameter int          BUMP_FRAMES = 8,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_RGB
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  block_x,
    input  logic [9:0]  block_y,
    input  logic [23:0] rom_color,
    output logic [8:0]  read_address,
    output logic [1:0]  frame_sel,
    output logic        pixel_on,
    output logic [23:0] pixel_color
);

    logic [1:0]  w_anim_frame;
    logic [3:0]  w_y_off;
    logic [9:0]  w_top;
    logic [9:0]  w_rel_x;
    logic [9:0]  w_rel_y;

    logic [8:0]  read_address_q, read_address_d;
    logic [1:0]  frame_sel_q;
    logic        in_q, in_d;
    logic        pixel_on_q, pixel_on_d;
    logic [23:0] pixel_color_q, pixel_color_d;

    qblock_anim_fsm #(
        .HOLD_FRAMES (HOLD_FRAMES),
        .BUMP_FRAMES (BUMP_FRAMES)
    ) u_anim (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick_i (frame_tick),
        .hit_i        (hit),
        .frame_sel_o  (w_anim_frame),
        .y_off_o      (w_y_off)
    );

    // Stage 1 combinational: offsets wrap in 10 bits so left/above misses
    // become large values and fail the bound test
    always_comb begin
        w_top          = block_y - {6'd0, w_y_off};
        w_rel_x        = DrawX - block_x;
        w_rel_y        = DrawY - w_top;
        in_d           = (w_rel_x < 10'(SPRITE_W)) && (w_rel_y < 10'(SPRITE_H));
        read_address_d = in_d ? 9'(w_rel_y * 10'(SPRITE_W) + w_rel_x) : 9'd0;
    end

    // Stage 2 combinational: key out the transparent colour
    always_comb begin
        pixel_on_d    = in_q && (rom_color != TRANSPARENT);
        pixel_color_d = pixel_on_d ? rom_color : 24'd0;
    end

    // Pipeline registers for both stages
    always_ff @(posedge Clk) begin
        if (Reset) begin
            read_address_q <= 9'd0;
            frame_sel_q    <= 2'd0;
            in_q           <= 1'b0;
            pixel_on_q     <= 1'b0;
            pixel_color_q  <= 24'd0;
        end else begin
            read_address_q <= read_address_d;
            frame_sel_q    <= w_anim_frame;
            in_q           <= in_d;
            pixel_on_q     <= pixel_on_d;
            pixel_color_q  <= pixel_color_d;
        end
    end

    assign read_address = read_address_q;
    assign frame_sel    = frame_sel_q;
    assign pixel_on     = pixel_on_q;
    assign pixel_color  = pixel_color_q;

endmodule
`default_nettype wire

// File: tb/tb_qblock_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_qblock_sprite_ctrl
// Purpose  : Directed stimulus with a behavioural reference model for
//            qblock_sprite_ctrl, plus hand-computed literal expectations
// Revision : 1.0  initial release
// ============================================================================
module tb_qblock_sprite_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic        hit;
    logic [9:0]  DrawX, DrawY, block_x, block_y;
    logic [23:0] rom_color;
    logic [8:0]  read_address;
    logic [1:0]  frame_sel;
    logic        pixel_on;
    logic [23:0] pixel_color;

    int n_pass  = 0;
    int n_total = 0;

    qblock_sprite_ctrl #(
        .SPRITE_W    (20),
        .SPRITE_H    (20),
        .HOLD_FRAMES (8),
        .BUMP_FRAMES (8),
        .TRANSPARENT (24'h800080)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .hit          (hit),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .block_x      (block_x),
        .block_y      (block_y),
        .rom_color    (rom_color),
        .read_address (read_address),
        .frame_sel    (frame_sel),
        .pixel_on     (pixel_on),
        .pixel_color  (pixel_color)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: animation described by tick counts, not state bits
    // ------------------------------------------------------------------
    int          ofs_tab [8] = '{2, 4, 6, 8, 8, 6, 4, 2};
    int          seq_tab [4] = '{0, 1, 2, 1};
    int          m_mode;        // 0 blink, 1 bump, 2 used
    int          m_blink_ticks;
    int          m_bump_ticks;
    bit          m_valid = 1'b0;
    logic [8:0]  e_addr;
    logic [1:0]  e_fsel;
    bit          e_in;
    logic        e_on;
    logic [23:0] e_col;

    always @(negedge Clk) begin
        int yoff;
        int top;
        int rx;
        int ry;
        if (m_valid) begin
            chk("cyc_read_address", 32'(read_address), 32'(e_addr));
            chk("cyc_frame_sel",    32'(frame_sel),    32'(e_fsel));
            chk("cyc_pixel_on",     32'(pixel_on),     32'(e_on));
            chk("cyc_pixel_color",  32'(pixel_color),  32'(e_col));
        end
        if (Reset) begin
            m_mode        = 0;
            m_blink_ticks = 0;
            m_bump_ticks  = 0;
            e_addr = '0; e_fsel = '0; e_in = 1'b0; e_on = 1'b0; e_col = '0;
            m_valid = 1'b1;
        end else begin
            e_on  = e_in && (rom_color != 24'h800080);
            e_col = e_on ? rom_color : 24'd0;
            yoff   = (m_mode == 1) ? ofs_tab[m_bump_ticks] : 0;
            e_fsel = (m_mode == 0) ? 2'(seq_tab[(m_blink_ticks % 32) / 8]) : 2'd3;
            top = (int'(block_y) - yoff) & 1023;
            rx  = (int'(DrawX) - int'(block_x)) & 1023;
            ry  = (int'(DrawY) - top) & 1023;
            e_in   = (rx < 20) && (ry < 20);
            e_addr = e_in ? 9'(ry * 20 + rx) : 9'd0;
            if (hit && m_mode == 0) begin
                m_mode       = 1;
                m_bump_ticks = 0;
            end else if (frame_tick) begin
                if (m_mode == 0) m_blink_ticks++;
                else if (m_mode == 1) begin
                    if (m_bump_ticks == 7) m_mode = 2;
                    else m_bump_ticks++;
                end
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        Reset = 1'b1; frame_tick = 1'b0; hit = 1'b0;
        DrawX = 10'd100; DrawY = 10'd50; block_x = 10'd100; block_y = 10'd50;
        rom_color = 24'h0;
        step(); step();
        chk("rst_read_address", 32'(read_address), 32'd0);
        chk("rst_frame_sel",    32'(frame_sel),    32'd0);
        chk("rst_pixel_on",     32'(pixel_on),     32'd0);
        chk("rst_pixel_color",  32'(pixel_color),  32'd0);

        // Top-left pixel: address 0, and inside (visible two cycles later)
        Reset = 1'b0; rom_color = 24'hE75A10;
        step();
        chk("tl_read_address", 32'(read_address), 32'd0);
        step();
        chk("tl_pixel_on", 32'(pixel_on), 32'd1);

        // Addressing
        DrawX = 10'd103; DrawY = 10'd52; step();
        chk("addr_43", 32'(read_address), 32'd43);
        DrawX = 10'd119; DrawY = 10'd69; step();
        chk("addr_399", 32'(read_address), 32'd399);
        DrawX = 10'd120; step();
        chk("addr_right_out", 32'(read_address), 32'd0);
        step();
        chk("pix_right_out", 32'(pixel_on), 32'd0);

        // Transparency
        DrawX = 10'd105; DrawY = 10'd55; rom_color = 24'h800080;
        step(); step();
        chk("transp_on",    32'(pixel_on),    32'd0);
        chk("transp_color", 32'(pixel_color), 32'd0);
        rom_color = 24'hE75A10; step();
        chk("opaque_on",    32'(pixel_on),    32'd1);
        chk("opaque_color", 32'(pixel_color), 32'hE75A10);

        // Blink timing over 32 ticks
        for (int k = 1; k <= 32; k++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
            if (k == 7)  chk("blink_t7",  32'(frame_sel), 32'd0);
            if (k == 8)  chk("blink_t8",  32'(frame_sel), 32'd1);
            if (k == 16) chk("blink_t16", 32'(frame_sel), 32'd2);
            if (k == 24) chk("blink_t24", 32'(frame_sel), 32'd1);
            if (k == 32) chk("blink_t32", 32'(frame_sel), 32'd0);
        end

        // Bump: hit coincident with a tick
        DrawX = 10'd101;
        hit = 1'b1; frame_tick = 1'b1; step();
        hit = 1'b0; frame_tick = 1'b0; DrawY = 10'd48; step();
        chk("bump_frame_sel", 32'(frame_sel), 32'd3);
        chk("bump_row0_y48",  32'(read_address), 32'd1);
        DrawY = 10'd47; step();
        chk("bump_above_out", 32'(read_address), 32'd0);
        for (int j = 1; j < 8; j++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; DrawY = 10'(50 - ofs_tab[j]); step();
            chk("bump_row0", 32'(read_address), 32'd1);
        end
        frame_tick = 1'b1; step();
        frame_tick = 1'b0; DrawY = 10'd50; step();
        chk("used_frame_sel", 32'(frame_sel),    32'd3);
        chk("used_row0_y50",  32'(read_address), 32'd1);
        hit = 1'b1; step();
        hit = 1'b0; frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
        chk("used_hit_frame", 32'(frame_sel),    32'd3);
        chk("used_hit_row0",  32'(read_address), 32'd1);

        // Column wrap: DrawX=1023 with block at column 0 is outside
        block_x = 10'd0; DrawX = 10'd1023; step();
        chk("wrap_addr", 32'(read_address), 32'd0);
        step();
        chk("wrap_pixel_on", 32'(pixel_on), 32'd0);
        block_x = 10'd100; DrawX = 10'd101;

        // Reset while bumping
        Reset = 1'b1; step();
        Reset = 1'b0; hit = 1'b1; step();
        hit = 1'b0; frame_tick = 1'b1; step();
        frame_tick = 1'b0; step();
        chk("prebump_frame", 32'(frame_sel), 32'd3);
        Reset = 1'b1; step();
        chk("midbump_rst_addr", 32'(read_address), 32'd0);
        Reset = 1'b0; DrawY = 10'd50; step();
        chk("midbump_frame", 32'(frame_sel),    32'd0);
        chk("midbump_yoff0", 32'(read_address), 32'd1);

        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
